// File: rtl/life_step.sv
// Game of Life generation engine: streams rows from a source memory through a
// three-row window and writes the next generation to a destination memory.
module life_step #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 200,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [15:0]           generation,
   output logic [ADDR_WIDTH-1:0] read_addr,
   output logic                  read_enable,
   input  logic [DATA_WIDTH-1:0] read_data,
   output logic [ADDR_WIDTH-1:0] write_addr,
   output logic                  write_enable,
   output logic [DATA_WIDTH-1:0] write_data
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_DRAIN = 3'd2;
   localparam logic [2:0] S_FLUSH = 3'd3;
   localparam logic [2:0] S_FIN   = 3'd4;

   localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(DEPTH - 1);

   logic [2:0]            state;
   logic                  vld_p1;
   logic                  have_row_p1;
   logic [ADDR_WIDTH-1:0] wr_idx;
   logic [DATA_WIDTH-1:0] prev_p1;
   logic [DATA_WIDTH-1:0] cur_p1;
   logic [DATA_WIDTH-1:0] below_p0;
   logic [DATA_WIDTH-1:0] next_p0;

   // Dead-padded neighbours on both sides, so edge columns never wrap around.
   function automatic logic [DATA_WIDTH-1:0] life_rule(
      input logic [DATA_WIDTH-1:0] up,
      input logic [DATA_WIDTH-1:0] mid,
      input logic [DATA_WIDTH-1:0] dn
   );
      logic [DATA_WIDTH+1:0] u;
      logic [DATA_WIDTH+1:0] m;
      logic [DATA_WIDTH+1:0] d;
      logic [3:0]            cnt;
      logic [DATA_WIDTH-1:0] res;
      u   = {1'b0, up, 1'b0};
      m   = {1'b0, mid, 1'b0};
      d   = {1'b0, dn, 1'b0};
      res = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         cnt = 4'(u[i]) + 4'(u[i+1]) + 4'(u[i+2])
             + 4'(m[i])              + 4'(m[i+2])
             + 4'(d[i]) + 4'(d[i+1]) + 4'(d[i+2]);
         res[i] = (cnt == 4'd3) || ((cnt == 4'd2) && m[i+1]);
      end
      return res;
   endfunction

   // Stage p0: combinational rule on the window plus the arriving row
   assign below_p0 = (state == S_FLUSH) ? '0 : read_data;
   assign next_p0  = life_rule(prev_p1, cur_p1, below_p0);
   assign busy     = (state != S_IDLE);

   // Stage p1: control, read sequencing and registered writes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         read_enable  <= 1'b0;
         read_addr    <= '0;
         vld_p1       <= 1'b0;
         have_row_p1  <= 1'b0;
         wr_idx       <= '0;
         write_enable <= 1'b0;
         write_addr   <= '0;
         write_data   <= '0;
         done         <= 1'b0;
         generation   <= '0;
      end else begin
         vld_p1       <= read_enable;
         write_enable <= 1'b0;
         done         <= 1'b0;
         if (done) begin
            generation <= generation + 16'd1;
         end
         case (state)
            S_IDLE: begin
               if (start) begin
                  state       <= S_READ;
                  read_enable <= 1'b1;
                  read_addr   <= '0;
                  have_row_p1 <= 1'b0;
                  wr_idx      <= '0;
               end
            end
            S_READ: begin
               if (read_addr == LAST_ROW) begin
                  state       <= S_DRAIN;
                  read_enable <= 1'b0;
                  read_addr   <= '0;
               end else begin
                  read_addr <= read_addr + ADDR_WIDTH'(1);
               end
            end
            S_DRAIN: state <= S_FLUSH;
            S_FLUSH: state <= S_FIN;
            S_FIN: begin
               state <= S_IDLE;
               done  <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
         // Row k arriving completes the neighbourhood of row k-1.
         if (vld_p1) begin
            have_row_p1 <= 1'b1;
            if (have_row_p1) begin
               write_enable <= 1'b1;
               write_addr   <= wr_idx;
               write_data   <= next_p0;
               wr_idx       <= wr_idx + ADDR_WIDTH'(1);
            end
         end
         if (state == S_FLUSH) begin
            write_enable <= 1'b1;
            write_addr   <= wr_idx;
            write_data   <= next_p0;
         end
      end
   end

   // Stage p1: rolling row window, cleared whenever a step begins
   always_ff @(posedge clk) begin
      if ((state == S_IDLE) && start) begin
         prev_p1 <= '0;
         cur_p1  <= '0;
      end else if (vld_p1) begin
         prev_p1 <= cur_p1;
         cur_p1  <= read_data;
      end
   end

endmodule

// File: tb/tb_life_step.sv
// Directed bench for life_step on a 8x5 grid with a behavioural source memory.
module tb_life_step;

   logic        clk;
   logic        reset;
   logic        start;
   logic        busy;
   logic        done;
   logic [15:0] generation;
   logic [7:0]  read_addr;
   logic        read_enable;
   logic [7:0]  read_data;
   logic [7:0]  write_addr;
   logic        write_enable;
   logic [7:0]  write_data;

   life_step #(.DATA_WIDTH(8), .DEPTH(5), .ADDR_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .generation(generation), .read_addr(read_addr), .read_enable(read_enable),
      .read_data(read_data), .write_addr(write_addr), .write_enable(write_enable),
      .write_data(write_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Source memory: one-cycle read latency, junk on the bus otherwise
   logic [7:0] src_mem [5];
   logic [7:0] rdata;
   logic       rd_vld;
   initial begin
      rdata  = 8'h00;
      rd_vld = 1'b0;
   end
   always @(posedge clk) begin
      rd_vld <= read_enable;
      if (read_enable && read_addr < 8'd5) rdata <= src_mem[read_addr[2:0]];
   end
   assign read_data = rd_vld ? rdata : 8'h5A;

   int n_checks = 0;
   int n_err    = 0;
   int exp_gen  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Write/done/read observer, sampled on the falling edge
   logic [7:0] wr_addr_log [16];
   logic [7:0] wr_data_log [16];
   int         wr_cyc_log  [16];
   int         wr_count, done_count, done_cyc, rd_count, rd_bad, busy_bad, s_cyc;
   bit         mon_on;
   logic       exp_busy;

   task automatic clear_mon();
      wr_count   = 0;
      done_count = 0;
      done_cyc   = -1;
      rd_count   = 0;
      rd_bad     = 0;
      busy_bad   = 0;
   endtask

   always @(negedge clk) begin
      if (write_enable) begin
         if (wr_count < 16) begin
            wr_addr_log[wr_count] = write_addr;
            wr_data_log[wr_count] = write_data;
            wr_cyc_log[wr_count]  = cyc;
         end
         wr_count++;
      end
      if (done) begin
         done_count++;
         done_cyc = cyc;
      end
      if (mon_on) begin
         if (read_enable) begin
            rd_count++;
            if (read_addr !== 8'(cyc - s_cyc - 1)) rd_bad++;
         end
         exp_busy = (cyc >= s_cyc + 1) && (cyc <= s_cyc + 8);
         if (busy !== exp_busy) busy_bad++;
      end
   end

   task automatic load_src(input logic [39:0] src);
      for (int k = 0; k < 5; k++) src_mem[k] = src[8*k +: 8];
   endtask

   task automatic run_step(input string name, input logic [39:0] src,
                           input logic [39:0] exp_rows, input bit extra_start);
      int n;
      load_src(src);
      clear_mon();
      @(negedge clk);
      start  = 1'b1;
      s_cyc  = cyc;
      mon_on = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (extra_start) begin
         repeat (2) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      n = 0;
      while (done_count == 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      repeat (6) @(negedge clk);
      mon_on = 1'b0;
      exp_gen++;
      chk({name, "_done_count"}, done_count, 1);
      chk({name, "_done_cycle"}, done_cyc, s_cyc + 9);
      chk({name, "_write_count"}, wr_count, 5);
      for (int j = 0; j < 5; j++) begin
         chk($sformatf("%s_wr%0d_addr", name, j), wr_addr_log[j], j);
         chk($sformatf("%s_wr%0d_cycle", name, j), wr_cyc_log[j], s_cyc + 4 + j);
         chk($sformatf("%s_wr%0d_data", name, j), wr_data_log[j], exp_rows[8*j +: 8]);
      end
      chk({name, "_read_count"}, rd_count, 5);
      chk({name, "_read_timing"}, rd_bad, 0);
      chk({name, "_busy_window"}, busy_bad, 0);
      chk({name, "_generation"}, generation, exp_gen);
   endtask

   typedef struct {
      string       name;
      logic [39:0] src;
      logic [39:0] exp;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int n;
      // Rows packed as {row4,row3,row2,row1,row0}
      vecs[0] = '{"blinker",     40'h00_08_08_08_00, 40'h00_00_1C_00_00};
      vecs[1] = '{"corner",      40'h00_00_00_03_03, 40'h00_00_00_03_03};
      vecs[2] = '{"bottom_edge", 40'h07_00_00_00_00, 40'h02_02_00_00_00};
      vecs[3] = '{"col7_edge",   40'h00_80_80_80_00, 40'h00_00_C0_00_00};
      vecs[4] = '{"full_grid",   40'hFF_FF_FF_FF_FF, 40'h81_00_00_00_81};

      mon_on = 1'b0;
      s_cyc  = 0;
      clear_mon();
      start = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_outputs_held", {busy, done, read_enable, write_enable, read_addr,
                                 write_addr, write_data, generation}, 64'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("reset_outputs_idle", {busy, done, read_enable, write_enable, read_addr,
                                 write_addr, write_data, generation}, 64'd0);

      for (int v = 0; v < 5; v++) run_step(vecs[v].name, vecs[v].src, vecs[v].exp, 1'b0);

      // A start pulse while busy must not launch a second sequence
      run_step("start_ignored", vecs[0].src, vecs[0].exp, 1'b1);

      // start held through done: next step follows with no gap
      load_src(vecs[0].src);
      clear_mon();
      @(negedge clk);
      start = 1'b1;
      s_cyc = cyc;
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("hold_done1_cycle", cyc, s_cyc + 9);
      @(negedge clk);
      exp_gen++;
      chk("hold_second_read", {read_enable, read_addr, cyc}, {1'b1, 8'h00, 32'(s_cyc + 10)});
      chk("hold_gen_after_first", generation, exp_gen);
      start = 1'b0;
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("hold_done2_cycle", cyc, s_cyc + 18);
      @(negedge clk);
      exp_gen++;
      chk("hold_gen_after_second", generation, exp_gen);
      chk("hold_write_count", wr_count, 10);
      chk("hold_done_count", done_count, 2);

      // Asynchronous reset in the middle of a step
      load_src(vecs[0].src);
      clear_mon();
      @(negedge clk);
      start = 1'b1;
      s_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      chk("midreset_outputs", {busy, done, read_enable, write_enable, read_addr,
                               write_addr, write_data, generation}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      exp_gen = 0;
      chk("midreset_no_done", done_count, 0);
      chk("midreset_writes_stopped", wr_count, 2);
      chk("midreset_generation", generation, 0);
      run_step("after_reset", vecs[0].src, vecs[0].exp, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $fatal(1);
   end

endmodule
